// File: rtl/operand_fetch.sv
// Register-read stage: 32x64 register file, per-register pending-write scoreboard,
// writeback bypass, RAW/WAW hazard stall and a single registered output slot toward execute.
module operand_fetch #(
  parameter int unsigned               BUS_DATA_WIDTH = 64,
  parameter logic [BUS_DATA_WIDTH-1:0] SP_INIT        = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [5:0]                in_alu_control,
  input  logic [4:0]                in_addressA,
  input  logic [4:0]                in_addressB,
  input  logic [4:0]                in_addressC,
  input  logic [BUS_DATA_WIDTH-1:0] in_imm,
  input  logic                      in_muxB_control,
  output logic                      stall,
  input  logic                      wb_en,
  input  logic [4:0]                wb_addr,
  input  logic [BUS_DATA_WIDTH-1:0] wb_data,
  input  logic                      ex_ready,
  output logic                      ex_valid,
  output logic [5:0]                ex_alu_control,
  output logic [BUS_DATA_WIDTH-1:0] ex_opA,
  output logic [BUS_DATA_WIDTH-1:0] ex_opB,
  output logic [4:0]                ex_addressC
);

  logic [BUS_DATA_WIDTH-1:0] rf_q [32];
  logic [31:0]               pend_q, pend_d;
  logic [31:0]               wb_hit, eff;
  logic [BUS_DATA_WIDTH-1:0] rd_a, rd_b, op_b;
  logic                      haz, slot_busy, acc, issue;

  logic                      ex_valid_q, ex_valid_d;
  logic [5:0]                ex_alu_q;
  logic [BUS_DATA_WIDTH-1:0] ex_opa_q, ex_opb_q;
  logic [4:0]                ex_c_q;

  // A retiring writeback releases its register in the same cycle it is written.
  always_comb begin
    wb_hit = '0;
    if (wb_en) wb_hit[wb_addr] = 1'b1;
    eff = pend_q & ~wb_hit;
  end

  always_comb begin
    if (in_addressA == '0)                     rd_a = '0;
    else if (wb_en && wb_addr == in_addressA)  rd_a = wb_data;
    else                                       rd_a = rf_q[in_addressA];
    if (in_addressB == '0)                     rd_b = '0;
    else if (wb_en && wb_addr == in_addressB)  rd_b = wb_data;
    else                                       rd_b = rf_q[in_addressB];
    op_b = in_muxB_control ? in_imm : rd_b;
  end

  assign haz       = in_valid && (eff[in_addressA] || (!in_muxB_control && eff[in_addressB])
                                  || eff[in_addressC]);
  assign slot_busy = ex_valid_q && !ex_ready;
  assign stall     = in_valid && (haz || slot_busy);
  assign acc       = in_valid && !stall;
  assign issue     = acc && (in_alu_control != '0);

  // Set after clear so a same-cycle issue to the retiring register keeps it pending.
  always_comb begin
    pend_d = pend_q & ~wb_hit;
    if (issue && in_addressC != '0) pend_d[in_addressC] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    if (issue)         ex_valid_d = 1'b1;
    else if (ex_ready) ex_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) rf_q[i[4:0]] <= '0;
      rf_q[2] <= SP_INIT;
    end else if (wb_en && wb_addr != '0) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q     <= '0;
      ex_valid_q <= 1'b0;
      ex_alu_q   <= '0;
      ex_opa_q   <= '0;
      ex_opb_q   <= '0;
      ex_c_q     <= '0;
    end else begin
      pend_q     <= pend_d;
      ex_valid_q <= ex_valid_d;
      if (issue) begin
        ex_alu_q <= in_alu_control;
        ex_opa_q <= rd_a;
        ex_opb_q <= op_b;
        ex_c_q   <= in_addressC;
      end
    end
  end

  assign ex_valid       = ex_valid_q;
  assign ex_alu_control = ex_alu_q;
  assign ex_opA         = ex_opa_q;
  assign ex_opB         = ex_opb_q;
  assign ex_addressC    = ex_c_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: expected ex_* transfers queued at issue and
// checked by a monitor on each accepted output; stall/reset checked inline.
module tb_operand_fetch;
  localparam int unsigned W  = 64;
  localparam logic [W-1:0] SP = 64'h0000_7FFF_FFF0_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [5:0]   in_alu_control;
  logic [4:0]   in_addressA, in_addressB, in_addressC;
  logic [W-1:0] in_imm;
  logic         in_muxB_control;
  logic         stall;
  logic         wb_en;
  logic [4:0]   wb_addr;
  logic [W-1:0] wb_data;
  logic         ex_ready;
  logic         ex_valid;
  logic [5:0]   ex_alu_control;
  logic [W-1:0] ex_opA, ex_opB;
  logic [4:0]   ex_addressC;

  operand_fetch #(.BUS_DATA_WIDTH(W), .SP_INIT(SP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_alu_control(in_alu_control),
    .in_addressA(in_addressA), .in_addressB(in_addressB), .in_addressC(in_addressC),
    .in_imm(in_imm), .in_muxB_control(in_muxB_control), .stall(stall),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_alu_control(ex_alu_control), .ex_opA(ex_opA),
    .ex_opB(ex_opB), .ex_addressC(ex_addressC)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]   alu;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   c;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [5:0] alu, input logic [4:0] a, input logic [4:0] b,
                    input logic [4:0] c, input logic mb, input logic [W-1:0] imm);
    in_valid = 1'b1; in_alu_control = alu; in_addressA = a; in_addressB = b;
    in_addressC = c; in_muxB_control = mb; in_imm = imm;
  endtask

  task automatic wb(input logic [4:0] ad, input logic [W-1:0] d);
    wb_en = 1'b1; wb_addr = ad; wb_data = d;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_alu_control = '0; wb_en = 1'b0;
  endtask

  task automatic st(input string name, input logic e);
    #1;
    chk(name, {63'd0, stall}, {63'd0, e});
  endtask

  task automatic push(input logic [5:0] alu, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [4:0] c);
    exp_t e;
    e = '{alu: alu, a: a, b: b, c: c};
    q.push_back(e);
  endtask

  // An output transfer happens at the edge where ex_valid && ex_ready.
  always @(negedge clk) begin
    exp_t g, e;
    if (reset === 1'b1 && ex_valid === 1'b1 && ex_ready === 1'b1) begin
      g = {ex_alu_control, ex_opA, ex_opB, ex_addressC};
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got alu=%h a=%h b=%h c=%0d expected none",
                 g.alu, g.a, g.b, g.c);
      end else begin
        e = q.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL sb_op: got alu=%h a=%h b=%h c=%0d expected alu=%h a=%h b=%h c=%0d",
                   g.alu, g.a, g.b, g.c, e.alu, e.a, e.b, e.c);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; ex_ready = 1'b1; wb_addr = '0; wb_data = '0;
    in_addressA = '0; in_addressB = '0; in_addressC = '0; in_imm = '0; in_muxB_control = 1'b0;
    idle();
    #2;
    chk("rst_stall", {63'd0, stall}, '0);
    chk("rst_ex_valid", {63'd0, ex_valid}, '0);
    chk("rst_ex_opA", ex_opA, '0);
    chk("rst_ex_opB", ex_opB, '0);
    chk("rst_ex_alu", {58'd0, ex_alu_control}, '0);
    chk("rst_ex_c", {59'd0, ex_addressC}, '0);
    step(); step();
    reset = 1'b1;

    // Reset register contents, back-to-back issue
    op(6'd1, 5'd2, 5'd0, 5'd0, 1'b1, '0);  st("iss_x2", 1'b0); push(6'd1, SP, '0, 5'd0); step();
    op(6'd2, 5'd5, 5'd5, 5'd0, 1'b0, '0);  st("iss_x5", 1'b0); push(6'd2, '0, '0, 5'd0); step();
    idle(); step();

    // Writeback then read; x0 reads; same-cycle bypass
    wb(5'd5, 64'h1234); step(); idle();
    op(6'd1, 5'd5, 5'd0, 5'd0, 1'b1, 64'd7); st("addi", 1'b0); push(6'd1, 64'h1234, 64'd7, 5'd0); step();
    op(6'd12, 5'd0, 5'd0, 5'd0, 1'b0, '0);   st("add_x0", 1'b0); push(6'd12, '0, '0, 5'd0); step();
    op(6'd2, 5'd8, 5'd5, 5'd0, 1'b0, '0); wb(5'd8, 64'h55);
    st("bypass", 1'b0); push(6'd2, 64'h55, 64'h1234, 5'd0); step(); idle();

    // RAW: consumer waits for x6 writeback, accepted in the writeback cycle
    op(6'd3, 5'd5, 5'd0, 5'd6, 1'b1, 64'd1); st("raw_prod", 1'b0); push(6'd3, 64'h1234, 64'd1, 5'd6); step();
    op(6'd4, 5'd6, 5'd0, 5'd10, 1'b1, 64'd2);
    for (int i = 0; i < 3; i++) begin st("raw_stall", 1'b1); step(); end
    wb(5'd6, 64'hAA); st("raw_release", 1'b0); push(6'd4, 64'hAA, 64'd2, 5'd10); step(); idle();
    wb(5'd10, 64'h10); step(); idle();

    // WAW, then set-wins on the same-cycle issue/writeback of x7
    op(6'd5, 5'd0, 5'd0, 5'd7, 1'b0, '0); st("waw_op1", 1'b0); push(6'd5, '0, '0, 5'd7); step();
    op(6'd6, 5'd0, 5'd0, 5'd7, 1'b1, 64'd3);
    st("waw_stall", 1'b1); step(); st("waw_stall", 1'b1);
    wb(5'd7, 64'h77); st("waw_release", 1'b0); push(6'd6, '0, 64'd3, 5'd7); step(); idle();
    op(6'd7, 5'd7, 5'd0, 5'd0, 1'b1, '0);
    st("set_wins", 1'b1); step(); st("set_wins", 1'b1);
    wb(5'd7, 64'h99); st("waw_op3_go", 1'b0); push(6'd7, 64'h99, '0, 5'd0); step(); idle();

    // Back-pressure: output slot held for 3 cycles
    op(6'd8, 5'd5, 5'd0, 5'd0, 1'b1, 64'd4); st("bp_first", 1'b0); push(6'd8, 64'h1234, 64'd4, 5'd0); step();
    ex_ready = 1'b0;
    op(6'd9, 5'd5, 5'd0, 5'd0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      st("bp_stall", 1'b1); step();
      chk("bp_hold_opA", ex_opA, 64'h1234);
      chk("bp_hold_opB", ex_opB, 64'd4);
      chk("bp_hold_alu", {58'd0, ex_alu_control}, 64'd8);
      chk("bp_hold_valid", {63'd0, ex_valid}, 64'd1);
    end
    ex_ready = 1'b1;
    st("bp_release", 1'b0); push(6'd9, 64'h1234, '0, 5'd0); step(); idle();

    // Drop: alu_control 0 consumed, no pend bit, ex_valid cleared
    op(6'd0, 5'd0, 5'd0, 5'd9, 1'b1, '0); st("drop_stall", 1'b0); step(); idle();
    chk("drop_ex_valid", {63'd0, ex_valid}, '0);
    op(6'd10, 5'd9, 5'd0, 5'd9, 1'b1, 64'd5); st("drop_nopend", 1'b0); push(6'd10, '0, 64'd5, 5'd9); step(); idle();
    wb(5'd9, 64'h9); step(); idle();

    // Spurious writeback still writes the register and leaves x11 free
    wb(5'd11, 64'hBB); step(); idle();
    op(6'd13, 5'd11, 5'd0, 5'd11, 1'b1, '0); st("spurious", 1'b0); push(6'd13, 64'hBB, '0, 5'd11); step();
    idle(); step();

    // Mid-run reset with x11 pending
    reset = 1'b0; #1;
    chk("mrst_ex_valid", {63'd0, ex_valid}, '0);
    chk("mrst_stall", {63'd0, stall}, '0);
    chk("mrst_ex_opA", ex_opA, '0);
    chk("mrst_ex_alu", {58'd0, ex_alu_control}, '0);
    step(); reset = 1'b1;
    op(6'd14, 5'd11, 5'd5, 5'd0, 1'b0, '0); st("mrst_pend_clr", 1'b0); push(6'd14, '0, '0, 5'd0); step();
    op(6'd15, 5'd2, 5'd0, 5'd0, 1'b1, 64'd1); st("mrst_sp", 1'b0); push(6'd15, SP, 64'd1, 5'd0); step();
    idle(); step(); step();
    chk("queue_drain", 64'(q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
